tinyalu_arbiter: RTL and testbench
==================================

TINYALU_ARBITER -- requirements
Module: tinyalu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum ISSUE cycles spent waiting for alu_done before a forced abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request; bit i belongs to requester i.
REQ-005 req_a  input  16  operand A; bits [8i+7:8i] belong to requester i.
REQ-006 req_b  input  16  operand B; same packing as req_a.
REQ-007 req_op  input  6  opcode; bits [3i+2:3i] belong to requester i.
REQ-008 req_ready  output  2  one-cycle grant/accept pulse to requester i.
REQ-009 rsp_valid  output  2  one-cycle response pulse to requester i.
REQ-010 rsp_result  output  16  result, shared by both requesters; valid when any bit of rsp_valid is 1.
REQ-011 rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-012 alu_a, alu_b  output  8 each  operands driven to the ALU.
REQ-013 alu_op  output  3  opcode driven to the ALU.
REQ-014 alu_start  output  1  start signal to the ALU.
REQ-015 alu_done  input  1  done signal from the ALU.
REQ-016 alu_result  input  16  result from the ALU.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-018 In IDLE with any req_valid bit set, the arbiter SHALL grant exactly one requester.
- It pulses req_ready[g] for that cycle.
- It registers the requester's A, B and op.
- It records the requester's index.
- It moves to RESP if op is local (REQ-021), otherwise to ISSUE.
REQ-019 Arbitration SHALL be round-robin.
- If both requesters are valid, grant the one not granted last.
- If only one is valid, grant it, whatever the pointer holds.
- The pointer updates on every grant.
REQ-020 A request is accepted only in a cycle where req_ready[i]=1; requester i SHALL hold req_valid and its operands stable until that pulse.
REQ-021 Opcode handling:
- ALU opcodes: 001 ADD, 010 AND, 011 XOR, 100 MULT.
- Local opcode 000 NOP: completes without the ALU, result 0, err 0.
- Local opcodes 101..111: complete without the ALU, result 0, err 1.
REQ-022 alu_start SHALL equal 1 exactly while the state is ISSUE.
- alu_a, alu_b and alu_op SHALL be driven from the registered request; they hold their value outside ISSUE.
REQ-023 In ISSUE, on alu_done=1 the arbiter SHALL register alu_result and err=0, then move to RESP.
- alu_start is therefore 0 in the following cycle.
- Latency: ADD/AND/XOR reach RESP 2 cycles after grant; MULT timing is set by the ALU's alu_done.
REQ-024 A cycle counter SHALL run in ISSUE, cleared on entry to ISSUE.
- If TIMEOUT cycles elapse without alu_done, the arbiter SHALL move to RESP with result 0 and err=1.
- If alu_done arrives in the same cycle the count reaches TIMEOUT, the done SHALL win: real result, err=0.
REQ-025 RESP SHALL last exactly one cycle.
- rsp_valid[g]=1 for that cycle; rsp_result and rsp_err are registered values.
- The next state is IDLE; no grant is made in RESP.
- A new grant can therefore occur one cycle after RESP.
REQ-026 There SHALL be no response backpressure; a requester not sampling rsp_valid loses the response.
REQ-027 At most one request SHALL be in flight; rsp_valid SHALL be one-hot or zero.
REQ-028 alu_done seen in IDLE or RESP SHALL be ignored.
REQ-029 A requester dropping req_valid before its grant SHALL simply not be granted.

Reset
REQ-030 While reset_n=0, and immediately on assertion (asynchronous), the block SHALL reset:
- State=IDLE.
- req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_op all 0.
- Counter 0.
- Round-robin pointer set so that requester 0 wins the first contention.
REQ-031 Reset mid-ISSUE SHALL abandon the in-flight request with no response; alu_start SHALL drop in the same cycle reset is asserted.

Verification
REQ-032 Requester 0, A=8'h12, B=8'h34, op ADD; ALU asserts done 1 cycle after start with result 16'h0046 -> req_ready=2'b01, alu_start for 2 cycles, rsp_valid=2'b01, rsp_result=16'h0046, rsp_err=0.
REQ-033 Both requesters valid in the same cycle after reset (req0 ADD 1+2, req1 MULT 8'hFF*8'hFF) -> req0 granted first (result 3); req1 granted 1 cycle after RESP (result 16'hFE01); a third contention goes to req0.
REQ-034 Requester 1, op 000 -> req_ready[1] pulse, next cycle rsp_valid=2'b10, result 0, err 0, alu_start never 1; op 110 gives the same timing with err=1.
REQ-035 ADD issued and the ALU never asserts done, TIMEOUT=8 -> alu_start high for exactly 8 cycles, then rsp_valid with result 0 and err=1, then IDLE.
REQ-036 reset_n pulsed low during a MULT in ISSUE -> alu_start=0 immediately, no rsp_valid; after release a new ADD 5+6 completes normally with result 11.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// Two-requester round-robin front end for a shared tinyalu: grants one request at a time,
// drives the ALU (or completes locally), and returns a one-cycle response with timeout abort.
module tinyalu_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [5:0]  req_op,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q;
    logic        idx_q;
    logic [7:0]  a_q, b_q;
    logic [2:0]  op_q;
    logic [7:0]  cnt_q;
    logic [15:0] result_q;
    logic        err_q;

    logic        grant;
    logic        gnt_idx;
    logic [7:0]  sel_a, sel_b;
    logic [2:0]  sel_op;
    logic        local_op;
    logic        timeout_hit;

    // Contention goes to whoever was not granted last; a lone requester always wins.
    assign gnt_idx     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    assign grant       = (state_q == IDLE) && (req_valid != 2'b00);
    assign sel_a       = gnt_idx ? req_a[15:8] : req_a[7:0];
    assign sel_b       = gnt_idx ? req_b[15:8] : req_b[7:0];
    assign sel_op      = gnt_idx ? req_op[5:3] : req_op[2:0];
    assign local_op    = (sel_op == 3'd0) || (sel_op >= 3'd5);
    assign timeout_hit = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = local_op ? RESP : ISSUE;
            ISSUE:   if (alu_done || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            idx_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_q <= gnt_idx;
                idx_q  <= gnt_idx;
                a_q    <= sel_a;
                b_q    <= sel_b;
                op_q   <= sel_op;
                cnt_q  <= '0;
                if (local_op) begin
                    result_q <= '0;
                    err_q    <= (sel_op != 3'd0);
                end
            end else if (state_q == ISSUE) begin
                // A done arriving on the final counted cycle beats the abort.
                if (alu_done) begin
                    result_q <= alu_result;
                    err_q    <= 1'b0;
                end else if (timeout_hit) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    // The reset gate keeps the grant pulse quiet while reset is held with requests pending.
    assign req_ready  = (grant && reset_n) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid  = (state_q == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign alu_start  = (state_q == ISSUE);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a small behavioural ALU whose done latency is adjustable.
module tb_tinyalu_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  req_ready, rsp_valid;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, alu_done;
    logic [15:0] alu_result;

    int n_checks = 0;
    int n_errors = 0;

    // ALU model: done after alu_lat start cycles have already elapsed; alu_never hangs it.
    int  alu_lat    = 1;
    bit  alu_never  = 0;
    bit  force_done = 0;
    int  st_cnt;

    tinyalu_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       st_cnt <= 0;
        else if (alu_start) st_cnt <= st_cnt + 1;
        else                st_cnt <= 0;
    end

    assign alu_done = force_done | (alu_start && !alu_never && (st_cnt == alu_lat));

    always_comb begin
        alu_result = 16'h0;
        case (alu_op)
            3'd1: alu_result = {8'h0, alu_a} + {8'h0, alu_b};
            3'd2: alu_result = {8'h0, alu_a & alu_b};
            3'd3: alu_result = {8'h0, alu_a ^ alu_b};
            3'd4: alu_result = {8'h0, alu_a} * {8'h0, alu_b};
            default: alu_result = 16'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (r == 0) begin
            req_a[7:0] = a; req_b[7:0] = b; req_op[2:0] = op;
        end else begin
            req_a[15:8] = a; req_b[15:8] = b; req_op[5:3] = op;
        end
        req_valid[r] = 1'b1;
    endtask

    // Called at a negedge: presents one request, checks the grant, then withdraws it.
    task automatic send(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [1:0] exp_ready);
        load(r, a, b, op);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    // Steps from the cycle after grant until a response appears, counting alu_start cycles.
    task automatic expect_rsp(input string tag, input int exp_cyc, input int exp_starts,
                              input logic [1:0] exp_rv, input logic [15:0] exp_res, input logic exp_err);
        int cyc = 0;
        int starts = 0;
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                seen = 1;
                break;
            end
            if (alu_start) starts++;
            cyc++;
            @(negedge clk);
        end
        if (!seen) begin
            check({tag, "_rsp_timeout"}, 32'(0), 32'(1));
        end else begin
            check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
            check({tag, "_starts"}, 32'(starts), 32'(exp_starts));
            check({tag, "_rv"}, 32'(rsp_valid), 32'(exp_rv));
            check({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
            check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 2'b11;
        req_a = 16'h0; req_b = 16'h0; req_op = 6'o11;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_alu_start", 32'(alu_start), 32'h0);
        check("rst_result", 32'({rsp_err, rsp_result}), 32'h0);
        check("rst_alu_ops", 32'({alu_a, alu_b, alu_op}), 32'h0);
        req_valid = 2'b00;
        reset_n = 1'b1;
        @(negedge clk);

        // Single ADD from requester 0.
        send("add0", 0, 8'h12, 8'h34, 3'd1, 2'b01);
        #1;
        check("add0_alu_a", 32'(alu_a), 32'h12);
        check("add0_alu_b", 32'(alu_b), 32'h34);
        check("add0_alu_op", 32'(alu_op), 32'h1);
        expect_rsp("add0", 2, 2, 2'b01, 16'h0046, 1'b0);
        @(negedge clk);
        #1;
        check("add0_idle_start", 32'(alu_start), 32'h0);
        check("add0_hold_a", 32'(alu_a), 32'h12);

        // Stray done in IDLE must not produce anything.
        force_done = 1;
        @(negedge clk);
        #1;
        check("idle_done_rv", 32'(rsp_valid), 32'h0);
        check("idle_done_start", 32'(alu_start), 32'h0);
        force_done = 0;
        @(negedge clk);

        // Contention: ADD 1+2 on req0, MULT FF*FF on req1. Pointer favours req0 after the req0 grant
        // above? Last grant was req0, so req1 would win: reset first to test the post-reset rule.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        alu_lat = 3;
        load(0, 8'h01, 8'h02, 3'd1);
        load(1, 8'hFF, 8'hFF, 3'd4);
        #1;
        check("cont_ready0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        expect_rsp("cont_req0", 4, 4, 2'b01, 16'h0003, 1'b0);
        check("cont_resp_nogrant", 32'(req_ready), 32'h0);
        @(negedge clk);
        #1;
        check("cont_ready1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        expect_rsp("cont_req1", 4, 4, 2'b10, 16'hFE01, 1'b0);
        @(negedge clk);
        load(0, 8'h00, 8'h00, 3'd0);
        load(1, 8'h00, 8'h00, 3'd0);
        #1;
        check("cont3_ready0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        expect_rsp("cont3", 0, 0, 2'b01, 16'h0, 1'b0);
        @(negedge clk);

        // Local opcodes on requester 1.
        send("nop1", 1, 8'h55, 8'h66, 3'd0, 2'b10);
        expect_rsp("nop1", 0, 0, 2'b10, 16'h0, 1'b0);
        @(negedge clk);
        send("bad1", 1, 8'h55, 8'h66, 3'd6, 2'b10);
        expect_rsp("bad1", 0, 0, 2'b10, 16'h0, 1'b1);
        @(negedge clk);

        // XOR on requester 1 with the default latency.
        alu_lat = 1;
        send("xor1", 1, 8'hF0, 8'h3C, 3'd3, 2'b10);
        expect_rsp("xor1", 2, 2, 2'b10, 16'h00CC, 1'b0);
        @(negedge clk);

        // Timeout: ALU never answers.
        alu_never = 1;
        send("tmo", 0, 8'h07, 8'h09, 3'd1, 2'b01);
        expect_rsp("tmo", 8, 8, 2'b01, 16'h0, 1'b1);
        @(negedge clk);
        #1;
        check("tmo_idle_start", 32'(alu_start), 32'h0);
        check("tmo_idle_rv", 32'(rsp_valid), 32'h0);
        alu_never = 0;
        @(negedge clk);

        // Done on the final counted cycle wins over the abort.
        alu_lat = 7;
        send("edge", 0, 8'h0F, 8'h3C, 3'd2, 2'b01);
        expect_rsp("edge", 8, 8, 2'b01, 16'h000C, 1'b0);
        @(negedge clk);

        // Reset during a MULT in ISSUE abandons it.
        alu_lat = 5;
        send("rmul", 0, 8'h10, 8'h10, 3'd4, 2'b01);
        #1;
        check("rmul_start_before", 32'(alu_start), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rmul_start_drop", 32'(alu_start), 32'h0);
        check("rmul_alu_a", 32'(alu_a), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rmul_no_rsp", 32'(rsp_valid), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("rmul_after_rv", 32'(rsp_valid), 32'h0);
        alu_lat = 1;
        send("add56", 0, 8'h05, 8'h06, 3'd1, 2'b01);
        expect_rsp("add56", 2, 2, 2'b01, 16'h000B, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
